// File: rtl/wb_retire_buf_if.sv
// MEM -> WB instruction handoff bundle: valid/allowin handshake plus the retire payload.
// Latency: none, wires only.
// Backpressure: the slave drives ws_allowin; the master holds ms2ws_valid and payload until accepted.
interface wb_retire_buf_if #(
    parameter int PC_W   = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ms2ws_valid;
    logic              ws_allowin;
    logic [PC_W-1:0]   ms_pc;
    logic              ms_rf_we;
    logic [ADDR_W-1:0] ms_rf_waddr;
    logic [DATA_W-1:0] ms_rf_wdata;
    logic              ms_csr_re;
    logic [13:0]       ms_csr_num;
    logic              ms_ex;
    logic [5:0]        ms_ecode;
    logic              ms_ertn;

    modport master (
        output ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
               ms_csr_re, ms_csr_num, ms_ex, ms_ecode, ms_ertn,
        input  ws_allowin
    );

    modport slave (
        input  ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
               ms_csr_re, ms_csr_num, ms_ex, ms_ecode, ms_ertn,
        output ws_allowin
    );
endinterface

// File: rtl/wb_retire_buf.sv
// In-order DEPTH-entry writeback retire buffer with exception/ertn flush, ID bypass and debug trace.
// Latency: accepted at edge N, earliest retirement at the edge ending cycle N+1; head outputs are combinational.
// Backpressure: ws_allowin = (count < DEPTH), no pop-through; the head stalls while rf_wr_ready is low.
// Optional bypass scan enabled by defining WB_RETIRE_BYPASS_EN; otherwise fwd_* outputs are tied to 0.
module wb_retire_buf #(
    parameter int DEPTH  = 4,    // power of two, >= 2
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32
) (
    input  logic                         clk,
    input  logic                         resetn,

    wb_retire_buf_if.slave               ms,

    // regfile write port (shared, granted by rf_wr_ready)
    input  logic                         rf_wr_ready,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,

    // CSR read at the head
    output logic                         csr_re,
    output logic [13:0]                  csr_num,
    input  logic [31:0]                  csr_rvalue,

    // exception / ertn retirement
    output logic                         wb_ex,
    output logic [5:0]                   wb_ecode,
    output logic [PC_W-1:0]              wb_pc,
    output logic                         ertn_flush,

    // ID bypass
    input  logic [ADDR_W-1:0]            id_raddr1,
    input  logic [ADDR_W-1:0]            id_raddr2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic                         fwd_stall,

    output logic [$clog2(DEPTH+1)-1:0]   occupancy,

    // debug trace
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Storage: valid bits are reset, payload is write-only on push
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_vld;

    logic [PC_W-1:0]   r_pc     [DEPTH];
    logic              r_we     [DEPTH];
    logic [ADDR_W-1:0] r_waddr  [DEPTH];
    logic [DATA_W-1:0] r_wdata  [DEPTH];
    logic              r_csr_re [DEPTH];
    logic [13:0]       r_csr_num[DEPTH];
    logic              r_ex     [DEPTH];
    logic [5:0]        r_ecode  [DEPTH];
    logic              r_ertn   [DEPTH];

    // ------------------------------------------------------------------
    // Head view and retire decision
    // ------------------------------------------------------------------
    logic              w_head_vld;
    logic              w_h_we;
    logic              w_h_ex;
    logic              w_h_ertn;
    logic              w_h_csr_re;
    logic [DATA_W-1:0] w_csr_val;
    logic [DATA_W-1:0] w_h_data;
    logic              w_allowin;
    logic              w_retire;
    logic              w_flush;
    logic              w_push;

    assign w_head_vld = r_vld[r_head];
    assign w_h_we     = r_we[r_head];
    assign w_h_ex     = r_ex[r_head];
    assign w_h_ertn   = r_ertn[r_head];
    assign w_h_csr_re = r_csr_re[r_head];
    assign w_csr_val  = DATA_W'(csr_rvalue);
    assign w_h_data   = w_h_csr_re ? w_csr_val : r_wdata[r_head];

    // Instructions that do not write a GPR, and excepting ones, do not need the regfile grant.
    assign w_retire   = w_head_vld & (rf_wr_ready | ~w_h_we | w_h_ex);

    // A full buffer refuses input even when the head leaves this cycle.
    assign w_allowin  = (r_count < DEPTH_C);
    assign ms.ws_allowin = w_allowin;

    assign wb_ex      = w_retire & w_h_ex;
    assign ertn_flush = w_retire & w_h_ertn & ~w_h_ex;
    assign w_flush    = wb_ex | ertn_flush;

    // A push coinciding with a flush belongs to the squashed path and is dropped.
    assign w_push     = ms.ms2ws_valid & w_allowin & ~w_flush;

    // ------------------------------------------------------------------
    // Head-driven outputs, all zero while the buffer is empty
    // ------------------------------------------------------------------
    assign rf_we      = w_retire & w_h_we & ~w_h_ex;
    assign rf_waddr   = w_head_vld ? r_waddr[r_head]   : '0;
    assign rf_wdata   = w_head_vld ? w_h_data          : '0;
    assign csr_re     = w_head_vld & w_h_csr_re;
    assign csr_num    = w_head_vld ? r_csr_num[r_head] : '0;
    assign wb_pc      = w_head_vld ? r_pc[r_head]      : '0;
    assign wb_ecode   = wb_ex      ? r_ecode[r_head]   : '0;
    assign occupancy  = r_count;

    assign debug_wb_pc       = 32'(wb_pc);
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = 5'(rf_waddr);
    assign debug_wb_rf_wdata = 32'(rf_wdata);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Pointer, count and valid bookkeeping; a flush empties the buffer outright.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_retire) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_retire);
        end
    end

    // Payload capture at the tail slot; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]      <= ms.ms_pc;
            r_we[r_tail]      <= ms.ms_rf_we;
            r_waddr[r_tail]   <= ms.ms_rf_waddr;
            r_wdata[r_tail]   <= ms.ms_rf_wdata;
            r_csr_re[r_tail]  <= ms.ms_csr_re;
            r_csr_num[r_tail] <= ms.ms_csr_num;
            r_ex[r_tail]      <= ms.ms_ex;
            r_ecode[r_tail]   <= ms.ms_ecode;
            r_ertn[r_tail]    <= ms.ms_ertn;
        end
    end

    // ------------------------------------------------------------------
    // ID bypass
    // ------------------------------------------------------------------
`ifdef WB_RETIRE_BYPASS_EN
    // Storage slot holding the i-th oldest entry (i = 0 is the head).
    logic [PTR_W-1:0]  w_age_idx [DEPTH];
    logic [ADDR_W-1:0] w_raddr   [2];
    logic [1:0]        w_hit;
    logic [1:0]        w_stl;
    logic [DATA_W-1:0] w_fdat    [2];

    for (genvar a = 0; a < DEPTH; a++) begin : g_age
        assign w_age_idx[a] = r_head + PTR_W'(a);
    end

    assign w_raddr[0] = id_raddr1;
    assign w_raddr[1] = id_raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic              w_found;
        logic              w_win_head;
        logic              w_win_csr;
        logic [DATA_W-1:0] w_win_data;

        // Walk oldest to youngest; each later match overrides, so the youngest producer wins.
        always_comb begin
            w_found    = 1'b0;
            w_win_head = 1'b0;
            w_win_csr  = 1'b0;
            w_win_data = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[w_age_idx[i]] && r_we[w_age_idx[i]] && !r_ex[w_age_idx[i]] &&
                    (r_waddr[w_age_idx[i]] == w_raddr[p]) && (w_raddr[p] != '0)) begin
                    w_found    = 1'b1;
                    w_win_head = (i == 0);
                    w_win_csr  = r_csr_re[w_age_idx[i]];
                    w_win_data = r_wdata[w_age_idx[i]];
                end
            end
        end

        // A CSR read is only resolved once it sits at the head; before that ID must wait.
        assign w_stl[p]  = w_found & w_win_csr & ~w_win_head;
        assign w_hit[p]  = w_found & ~w_stl[p];
        assign w_fdat[p] = !w_hit[p] ? '0 : (w_win_csr ? w_csr_val : w_win_data);
    end

    assign fwd_hit1  = w_hit[0];
    assign fwd_hit2  = w_hit[1];
    assign fwd_data1 = w_fdat[0];
    assign fwd_data2 = w_fdat[1];
    assign fwd_stall = |w_stl;
`else
    // Without bypass ID reads the regfile after retirement; the read indices are not needed here.
    logic w_unused_raddr;
    assign w_unused_raddr = ^{id_raddr1, id_raddr2};

    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
    assign fwd_stall = 1'b0;
`endif

endmodule
